// File: rtl/typedefs_pkg.sv
// Shared types for the execute/memory slice: ALU operation select,
// major opcodes and a packed instruction union with R/I/S views.
package typedefs_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_SLT  = 4'd8,
    ALU_SLTU = 4'd9
  } aluop_sel_t;

  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef struct packed {
    logic [6:0] funct7;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [6:0] opcode;
  } r_type_t;

  typedef struct packed {
    logic [11:0] imm;
    logic [4:0]  rs1;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic [6:0]  opcode;
  } i_type_t;

  typedef struct packed {
    logic [6:0] imm_hi;
    logic [4:0] rs2;
    logic [4:0] rs1;
    logic [2:0] funct3;
    logic [4:0] imm_lo;
    logic [6:0] opcode;
  } s_type_t;

  typedef union packed {
    r_type_t     r;
    i_type_t     i;
    s_type_t     s;
    logic [31:0] raw;
  } instr_t;

endpackage

// File: rtl/exec_alu.sv
// Combinational ALU. Ports: a, b (in), sel (in) -> res (out).
// Unused select codes produce 0.
module exec_alu
  import typedefs_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [3:0]      sel,
  output logic [XLEN-1:0] res
);
  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt;
  assign shamt = b[SHW-1:0];

  always_comb begin
    res = '0;
    case (sel)
      ALU_ADD:  res = a + b;
      ALU_SUB:  res = a - b;
      ALU_AND:  res = a & b;
      ALU_OR:   res = a | b;
      ALU_XOR:  res = a ^ b;
      ALU_SLL:  res = a << shamt;
      ALU_SRL:  res = a >> shamt;
      ALU_SRA:  res = XLEN'($signed(a) >>> shamt);
      ALU_SLT:  res = {{(XLEN-1){1'b0}}, $signed(a) < $signed(b)};
      ALU_SLTU: res = {{(XLEN-1){1'b0}}, a < b};
      default:  res = '0;
    endcase
  end

endmodule

// File: rtl/exec_ctrl_decode.sv
// Combinational control decode.
// Ports: instr (in) -> alu_sel, alu_src, mem_wen, reg_wen, imm_src,
// reg_wdata_src (out).
module exec_ctrl_decode
  import typedefs_pkg::*;
(
  input  logic [31:0] instr,
  output aluop_sel_t  alu_sel,
  output logic        alu_src,
  output logic        mem_wen,
  output logic        reg_wen,
  output logic        imm_src,
  output logic        reg_wdata_src
);
  instr_t     ins;
  aluop_sel_t arith_sel;
  logic       unused_fields;

  assign ins           = instr;
  assign unused_fields = ^{ins.r.rs2, ins.r.rs1, ins.r.rd};

  // funct3/funct7 -> op for the ALU-type opcodes. SUB only exists for R;
  // funct7[5] selects SRA for both R and I shifts.
  always_comb begin
    arith_sel = ALU_ADD;
    case (ins.r.funct3)
      3'b000: arith_sel = (ins.r.opcode == OP_R && ins.r.funct7 == 7'b0100000) ? ALU_SUB : ALU_ADD;
      3'b001: arith_sel = ALU_SLL;
      3'b010: arith_sel = ALU_SLT;
      3'b011: arith_sel = ALU_SLTU;
      3'b100: arith_sel = ALU_XOR;
      3'b101: arith_sel = ins.r.funct7[5] ? ALU_SRA : ALU_SRL;
      3'b110: arith_sel = ALU_OR;
      3'b111: arith_sel = ALU_AND;
      default: arith_sel = ALU_ADD;
    endcase
  end

  always_comb begin
    alu_sel       = ALU_ADD;
    alu_src       = 1'b0;
    mem_wen       = 1'b0;
    reg_wen       = 1'b0;
    imm_src       = 1'b0;
    reg_wdata_src = 1'b0;
    case (ins.r.opcode)
      OP_R: begin
        reg_wen = 1'b1;
        alu_sel = arith_sel;
      end
      OP_IMM: begin
        alu_src = 1'b1;
        reg_wen = 1'b1;
        alu_sel = arith_sel;
      end
      OP_LOAD: begin
        alu_src       = 1'b1;
        reg_wen       = 1'b1;
        reg_wdata_src = 1'b1;
      end
      OP_STORE: begin
        alu_src = 1'b1;
        mem_wen = 1'b1;
        imm_src = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/exec_dmem.sv
// Byte-addressed little-endian data memory with store-width masking.
// Ports: clk, rst (async high, clears every byte), wen, funct3 (store
// width), addr (byte address), wdata -> rdata (combinational word read).
// Lane addresses wrap modulo the memory size, so misaligned and
// end-of-memory accesses simply roll over to byte 0.
module exec_dmem #(
  parameter int XLEN   = 32,
  parameter int AWIDTH = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wen,
  input  logic [2:0]        funct3,
  input  logic [AWIDTH-1:0] addr,
  input  logic [XLEN-1:0]   wdata,
  output logic [XLEN-1:0]   rdata
);
  localparam int NB    = XLEN / 8;
  localparam int DEPTH = 1 << AWIDTH;

  logic [7:0]                  mem [DEPTH];
  logic [NB-1:0][AWIDTH-1:0]   lane_addr;
  logic [NB-1:0]               mask;

  for (genvar g = 0; g < NB; g++) begin : g_lane
    assign lane_addr[g]     = addr + AWIDTH'(g);
    assign rdata[8*g +: 8]  = mem[lane_addr[g]];
  end

  always_comb begin
    mask = '0;
    case (funct3)
      3'b000:  mask = NB'(1);
      3'b001:  mask = NB'(3);
      3'b010:  mask = '1;
      default: mask = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wen) begin
      for (int b = 0; b < NB; b++)
        if (mask[b]) mem[lane_addr[b]] <= wdata[8*b +: 8];
    end
  end

endmodule

// File: rtl/exec_mem_unit.sv
// Execute/memory slice of a single-cycle RV32I datapath: control decode,
// operand-2 select, ALU and data memory.
// Ports: clk, rst (async high); instr, rs1_data, rs2_data, imm_ext in;
// alu_res (also the memory byte address), res_is_0, dmem_rdata and the
// decoded controls alu_sel, alu_src, mem_wen, reg_wen, imm_src,
// reg_wdata_src out.
module exec_mem_unit
  import typedefs_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int DMEM_AWIDTH = 10
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic [XLEN-1:0] imm_ext,
  output logic [XLEN-1:0] alu_res,
  output logic            res_is_0,
  output logic [XLEN-1:0] dmem_rdata,
  output logic [3:0]      alu_sel,
  output logic            alu_src,
  output logic            mem_wen,
  output logic            reg_wen,
  output logic            imm_src,
  output logic            reg_wdata_src
);
  aluop_sel_t      sel;
  logic [XLEN-1:0] op2;

  exec_ctrl_decode u_dec (
    .instr         (instr),
    .alu_sel       (sel),
    .alu_src       (alu_src),
    .mem_wen       (mem_wen),
    .reg_wen       (reg_wen),
    .imm_src       (imm_src),
    .reg_wdata_src (reg_wdata_src)
  );

  assign alu_sel = sel;
  assign op2     = alu_src ? imm_ext : rs2_data;

  exec_alu #(.XLEN(XLEN)) u_alu (
    .a   (rs1_data),
    .b   (op2),
    .sel (sel),
    .res (alu_res)
  );

  assign res_is_0 = (alu_res == '0);

  exec_dmem #(.XLEN(XLEN), .AWIDTH(DMEM_AWIDTH)) u_dmem (
    .clk    (clk),
    .rst    (rst),
    .wen    (mem_wen),
    .funct3 (instr[14:12]),
    .addr   (alu_res[DMEM_AWIDTH-1:0]),
    .wdata  (rs2_data),
    .rdata  (dmem_rdata)
  );

endmodule

// File: tb/tb_exec_mem_unit.sv
module tb_exec_mem_unit;
  import typedefs_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] instr = '0, rs1_data = '0, rs2_data = '0, imm_ext = '0;
  logic [31:0] alu_res, dmem_rdata;
  logic        res_is_0, alu_src, mem_wen, reg_wen, imm_src, reg_wdata_src;
  logic [3:0]  alu_sel;

  exec_mem_unit dut (
    .clk(clk), .rst(rst), .instr(instr), .rs1_data(rs1_data),
    .rs2_data(rs2_data), .imm_ext(imm_ext), .alu_res(alu_res),
    .res_is_0(res_is_0), .dmem_rdata(dmem_rdata), .alu_sel(alu_sel),
    .alu_src(alu_src), .mem_wen(mem_wen), .reg_wen(reg_wen),
    .imm_src(imm_src), .reg_wdata_src(reg_wdata_src)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          id;
    logic [31:0] res, rdata;
    logic        z, src, mwen, rwen, isrc, wsrc;
    logic [3:0]  sel;
  } exp_t;

  exp_t        expq[$];
  logic [7:0]  ref_mem [1024];
  int          n_chk = 0, n_fail = 0, n_txn = 0;

  // Reference behaviour written from the instruction set rules.
  function automatic exp_t model(input logic [31:0] ins, a, b2, im);
    exp_t e;
    logic [6:0]  opc = ins[6:0];
    logic [2:0]  f3  = ins[14:12];
    logic [6:0]  f7  = ins[31:25];
    logic [31:0] b;
    logic [9:0]  ad;
    bit is_r  = (opc == 7'b0110011);
    bit is_i  = (opc == 7'b0010011);
    bit is_ld = (opc == 7'b0000011);
    bit is_st = (opc == 7'b0100011);
    int op = 0;
    e.id   = n_txn;
    e.src  = is_i || is_ld || is_st;
    e.rwen = is_r || is_i || is_ld;
    e.mwen = is_st;
    e.isrc = is_st;
    e.wsrc = is_ld;
    if (is_r || is_i) begin
      case (f3)
        3'd0: op = (is_r && f7 == 7'h20) ? 1 : 0;
        3'd1: op = 5;
        3'd2: op = 8;
        3'd3: op = 9;
        3'd4: op = 4;
        3'd5: op = f7[5] ? 7 : 6;
        3'd6: op = 3;
        default: op = 2;
      endcase
    end
    e.sel = 4'(op);
    b = e.src ? im : b2;
    case (op)
      0: e.res = a + b;
      1: e.res = a - b;
      2: e.res = a & b;
      3: e.res = a | b;
      4: e.res = a ^ b;
      5: e.res = a << b[4:0];
      6: e.res = a >> b[4:0];
      7: e.res = 32'($signed(a) >>> b[4:0]);
      8: e.res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: e.res = (a < b) ? 32'd1 : 32'd0;
    endcase
    e.z = (e.res == 0);
    ad = e.res[9:0];
    e.rdata = {ref_mem[10'(ad + 10'd3)], ref_mem[10'(ad + 10'd2)],
               ref_mem[10'(ad + 10'd1)], ref_mem[ad]};
    return e;
  endfunction

  task automatic issue(input logic r, input logic [31:0] ins, a, b2, im);
    exp_t e;
    int   nb;
    @(posedge clk); #1;
    rst = r; instr = ins; rs1_data = a; rs2_data = b2; imm_ext = im;
    if (r) for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;
    e = model(ins, a, b2, im);
    expq.push_back(e);
    n_txn++;
    // Store lands at the next rising edge, before the next transaction.
    if (!r && e.mwen) begin
      nb = (ins[14:12] == 3'd0) ? 1 : (ins[14:12] == 3'd1) ? 2 : (ins[14:12] == 3'd2) ? 4 : 0;
      for (int k = 0; k < nb; k++)
        ref_mem[10'(e.res[9:0] + 10'(k))] = b2[8*k +: 8];
    end
  endtask

  function automatic void chk(input string nm, input int id, input logic [31:0] act, exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s txn %0d: got %h expected %h", nm, id, act, exp);
    end
  endfunction

  // Monitor: results are combinational, so each issued transaction is
  // presented in its own cycle and sampled on the falling edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("alu_res",       e.id, alu_res,       e.res);
        chk("res_is_0",      e.id, 32'(res_is_0), 32'(e.z));
        chk("dmem_rdata",    e.id, dmem_rdata,    e.rdata);
        chk("alu_sel",       e.id, 32'(alu_sel),  32'(e.sel));
        chk("alu_src",       e.id, 32'(alu_src),  32'(e.src));
        chk("mem_wen",       e.id, 32'(mem_wen),  32'(e.mwen));
        chk("reg_wen",       e.id, 32'(reg_wen),  32'(e.rwen));
        chk("imm_src",       e.id, 32'(imm_src),  32'(e.isrc));
        chk("reg_wdata_src", e.id, 32'(reg_wdata_src), 32'(e.wsrc));
      end
    end
  end

  function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3);
    return {f7, 5'd2, 5'd1, f3, 5'd3, OP_R};
  endfunction
  function automatic logic [31:0] enc_i(input logic [11:0] im, input logic [2:0] f3);
    return {im, 5'd1, f3, 5'd3, OP_IMM};
  endfunction
  function automatic logic [31:0] enc_l(input logic [2:0] f3);
    return {12'd0, 5'd1, f3, 5'd3, OP_LOAD};
  endfunction
  function automatic logic [31:0] enc_s(input logic [2:0] f3);
    return {7'd0, 5'd2, 5'd1, f3, 5'd0, OP_STORE};
  endfunction

  initial begin
    logic [31:0] ins, a, b2, im;
    logic [6:0]  opc, f7;
    logic [2:0]  f3;
    int          k;
    for (int i = 0; i < 1024; i++) ref_mem[i] = 8'h00;

    issue(1'b1, 32'h00500093, 0, 0, 5);                 // reset state, ADDI
    issue(1'b0, 32'h00500093, 0, 0, 5);
    issue(1'b0, enc_r(7'h20, 3'd0), 7, 7, 0);           // SUB -> 0
    issue(1'b0, enc_r(7'h20, 3'd5), 32'h80000000, 4, 0); // SRA
    issue(1'b0, enc_r(7'h00, 3'd3), 1, 32'hFFFFFFFF, 0); // SLTU
    issue(1'b0, enc_s(3'd2), 0, 32'hDEADBEEF, 8);       // SW @8
    issue(1'b0, enc_l(3'd2), 0, 0, 8);
    issue(1'b0, enc_s(3'd0), 9, 32'h12345678, 0);       // SB @9
    issue(1'b0, enc_l(3'd2), 8, 0, 0);
    issue(1'b0, enc_s(3'd1), 0, 32'hAAAA5555, 10);      // SH @10
    issue(1'b0, enc_l(3'd2), 0, 0, 8);
    issue(1'b0, enc_s(3'd3), 8, 32'hFFFFFFFF, 0);       // no-byte store
    issue(1'b0, enc_l(3'd2), 8, 0, 0);
    issue(1'b0, enc_s(3'd2), 1000, 32'h11223344, 22);   // SW @1022 wraps
    issue(1'b0, enc_l(3'd2), 1022, 0, 0);
    issue(1'b0, enc_l(3'd2), 0, 0, 0);
    issue(1'b0, enc_l(3'd2), 32'h400, 0, 0);            // alias of 0
    issue(1'b0, enc_s(3'd2), 0, 32'hCAFEF00D, 8);
    issue(1'b1, enc_s(3'd2), 0, 32'h55555555, 8);       // rst between edges, store blocked
    issue(1'b0, enc_l(3'd2), 0, 0, 8);

    for (int n = 0; n < 400; n++) begin
      k  = $urandom_range(0, 9);
      f3 = 3'($urandom);
      k  = k;
      case ($urandom_range(0, 3))
        0, 1: f7 = 7'h00;
        2:    f7 = 7'h20;
        default: f7 = 7'($urandom);
      endcase
      a  = $urandom;
      b2 = ($urandom_range(0, 7) == 0) ? a : $urandom;
      im = $urandom;
      if (k <= 2) opc = OP_R;
      else if (k <= 4) opc = OP_IMM;
      else if (k <= 6) opc = OP_LOAD;
      else if (k <= 8) opc = OP_STORE;
      else opc = 7'($urandom);
      if (opc == OP_LOAD || opc == OP_STORE) begin
        a  = $urandom_range(0, 1100);
        im = $urandom_range(0, 15);
        if (opc == OP_STORE) f3 = 3'($urandom_range(0, 3));
      end
      ins = {f7, 10'($urandom), f3, 5'($urandom), opc};
      issue($urandom_range(0, 49) == 0, ins, a, b2, im);
    end

    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    @(posedge clk);
    n_chk++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", expq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/exec_mem_unit.md
Name: exec_mem_unit

Overview:
- Execute/memory slice of the single-cycle RV32I datapath: instruction decode (control), ALU with operand-2 select, and byte-addressed data memory with store-width masking.
- Fed by the register bank (rs1/rs2 data) and the immediate extender.
- Drives the register write-back mux and the load extender.
- Supports R-type ALU, I-type ALU, loads and stores.

Parameters:
- XLEN, 32, datapath width.
- DMEM_AWIDTH, 10, data memory byte-address width (2**DMEM_AWIDTH = 1024 bytes).

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr  in  32  current instruction (opcode [6:0], funct3 [14:12], funct7 [31:25]).
- rs1_data  in  XLEN  ALU operand 1.
- rs2_data  in  XLEN  ALU operand 2 (register) and store data.
- imm_ext  in  XLEN  sign-extended immediate.
- alu_res  out  XLEN  ALU result; also the memory byte address.
- res_is_0  out  1  alu_res == 0.
- dmem_rdata  out  XLEN  word read at alu_res.
- alu_sel  out  4  decoded ALU operation (aluop_sel_t).
- alu_src  out  1  1 = operand 2 is imm_ext, 0 = rs2_data.
- mem_wen  out  1  store enable.
- reg_wen  out  1  register write enable.
- imm_src  out  1  0 = I-type immediate, 1 = S-type immediate.
- reg_wdata_src  out  1  0 = write-back ALU result, 1 = load data.

Behaviour:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- Decode is purely combinational.
- Opcode 0110011 (R): alu_src=0, reg_wen=1, mem_wen=0, imm_src=0, reg_wdata_src=0.
- Opcode 0010011 (I-ALU): alu_src=1, reg_wen=1, mem_wen=0, imm_src=0, reg_wdata_src=0.
- Opcode 0000011 (LOAD): alu_src=1, reg_wen=1, mem_wen=0, imm_src=0, reg_wdata_src=1, alu_sel=ADD.
- Opcode 0100011 (STORE): alu_src=1, reg_wen=0, mem_wen=1, imm_src=1, reg_wdata_src=0, alu_sel=ADD.
- Any other opcode (including X): all enables 0, alu_src=0, alu_sel=ADD.
- ALU select from funct3: 000 ADD (SUB if R-type and funct7=0100000), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct7[5]=1, R or I), 110 OR, 111 AND.
- I-type funct3=000 is always ADD.
- alu_sel encoding: ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9.
- ALU is combinational; ADD/SUB wrap modulo 2**XLEN; shift amount = operand2[4:0].
- SLT/SLTU return 1 or 0 (signed/unsigned compare).
- Undefined alu_sel yields 0.
- Data memory: byte array, little-endian.
- Read is combinational: dmem_rdata = bytes {a+3,a+2,a+1,a}, a = alu_res[DMEM_AWIDTH-1:0]; byte indices wrap modulo memory size.
- Misaligned access is permitted and has no trap.
- Write on rising clk when mem_wen=1, using store mask from funct3: 000 -> byte 0 only (SB); 001 -> bytes 0-1 (SH); 010 -> all 4 bytes (SW); other -> no bytes.
- Masked bytes of rs2_data go to a, a+1, ... (wrapping); unmasked bytes are unchanged.
- Address bits above DMEM_AWIDTH are ignored.
- Reset: all memory bytes clear to 0 immediately; writes are suppressed while rst=1; dmem_rdata reads 0 during and after reset until written.
- Reset asserted mid-write: the clear wins and no write occurs in that cycle.
- Control and ALU outputs have no reset state; they follow their inputs combinationally.
- Latency: a store is visible on dmem_rdata in the cycle after its clock edge; a load returns data in the same cycle.

Decomposition:
- Shared package typedefs_pkg holds:
  - aluop_sel_t enum;
  - opcode constants OP_R, OP_IMM, OP_LOAD, OP_STORE;
  - instr_t union with R/I/S views.
- Natural sub-modules: exec_ctrl_decode (opcode/funct to control), exec_alu, exec_dmem (masked byte memory).
- Top wires these sub-modules together with the operand-2 mux.

Test Plan:
- ADDI x1,x0,5 (instr 0x00500093, rs1_data=0, imm_ext=5) -> alu_res=5, reg_wen=1, alu_src=1, mem_wen=0, res_is_0=0.
- SUB with rs1_data=7, rs2_data=7 -> alu_res=0, res_is_0=1.
- SRA with rs1_data=0x80000000, rs2_data=4 -> 0xF8000000.
- SLTU with 1 and 0xFFFFFFFF -> 1.
- SW rs2_data=0xDEADBEEF at address 8, then LW at 8 -> dmem_rdata=0xDEADBEEF; mem_wen=1, reg_wen=0 on the SW.
- SB 0x12345678 to address 9 over that word -> word at 8 reads 0xDEAD78EF.
- SH 0xAAAA5555 to address 10 -> word at 8 reads 0x555578EF.
- Store with funct3=011 -> memory unchanged.
- Write to address 1022 (SW 0x11223344) -> bytes 1022, 1023, 0, 1 written.
- Address 0x400 aliases to 0.
- Assert rst asynchronously between clock edges after stores -> all reads 0 immediately.
- Store attempted while rst=1 is ignored.
